// File: rtl/axil_crossbar_wr_route.sv
// rtl/axil_crossbar_wr_route.sv - AXI-Lite write-path router, one master to NUMBER_SLAVE slaves
//
// Routes one AXI-Lite write transaction at a time from the master port to the
// slave chosen by the one-hot decoder grant. The grant is latched when the
// transaction starts, and the route is held until the B handshake completes.
// Zero or multi-hot grants are answered locally with DECERR. A slave that stalls
// for TIMEOUT_CYCLES cycles is abandoned and answered locally with SLVERR.
//
// Ports
//   aclk, aresetn        clock, asynchronous active-low reset
//   grant_wr_trans       one-hot slave select, sampled only while idle
//   m_axil_aw*/w*/b*     master-side write channels
//   s_axil_aw*/w*/b*     slave-side write channels; address/data/strobe broadcast,
//                        valid/ready per slave, s_axil_bresp unpacked per slave
//   busy                 high whenever a transaction is in progress

module axil_crossbar_wr_route #(
    parameter int NUMBER_SLAVE   = 8,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [NUMBER_SLAVE-1:0]     grant_wr_trans,
    input  logic [AXI_ADDR_WIDTH-1:0]   m_axil_awaddr,
    input  logic                        m_axil_awvalid,
    output logic                        m_axil_awready,
    input  logic [AXI_DATA_WIDTH-1:0]   m_axil_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] m_axil_wstrb,
    input  logic                        m_axil_wvalid,
    output logic                        m_axil_wready,
    output logic [1:0]                  m_axil_bresp,
    output logic                        m_axil_bvalid,
    input  logic                        m_axil_bready,
    output logic [AXI_ADDR_WIDTH-1:0]   s_axil_awaddr,
    output logic [NUMBER_SLAVE-1:0]     s_axil_awvalid,
    input  logic [NUMBER_SLAVE-1:0]     s_axil_awready,
    output logic [AXI_DATA_WIDTH-1:0]   s_axil_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] s_axil_wstrb,
    output logic [NUMBER_SLAVE-1:0]     s_axil_wvalid,
    input  logic [NUMBER_SLAVE-1:0]     s_axil_wready,
    input  logic [1:0]                  s_axil_bresp [NUMBER_SLAVE],
    input  logic [NUMBER_SLAVE-1:0]     s_axil_bvalid,
    output logic [NUMBER_SLAVE-1:0]     s_axil_bready,
    output logic                        busy
);

    localparam int TIMER_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST =
        TIMER_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_RESP = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [NUMBER_SLAVE-1:0] r_sel;
    logic                    r_aw_done;
    logic                    r_w_done;
    logic [1:0]              r_err_code;
    logic [TIMER_W-1:0]      r_timer;

    logic                    w_grant_onehot;
    logic                    w_sel_awready;
    logic                    w_sel_wready;
    logic                    w_sel_bvalid;
    logic [1:0]              w_sel_bresp;
    logic                    w_aw_hs;
    logic                    w_w_hs;
    logic                    w_b_hs;
    logic                    w_any_hs;
    logic                    w_timeout;

    // Address and data are broadcast; only the per-slave valids steer them.
    assign s_axil_awaddr = m_axil_awaddr;
    assign s_axil_wdata  = m_axil_wdata;
    assign s_axil_wstrb  = m_axil_wstrb;

    assign busy = (r_state != S_IDLE);

    assign w_grant_onehot = (grant_wr_trans != '0) &&
                            ((grant_wr_trans & (grant_wr_trans - 1'b1)) == '0);

    // r_sel is one-hot (or zero), so masking and OR-reducing picks the selected slave.
    assign w_sel_awready = |(s_axil_awready & r_sel);
    assign w_sel_wready  = |(s_axil_wready  & r_sel);
    assign w_sel_bvalid  = |(s_axil_bvalid  & r_sel);

    always_comb begin
        w_sel_bresp = 2'b00;
        for (int i = 0; i < NUMBER_SLAVE; i++) begin
            w_sel_bresp = w_sel_bresp | ({2{r_sel[i]}} & s_axil_bresp[i]);
        end
    end

    assign w_aw_hs  = m_axil_awvalid & m_axil_awready;
    assign w_w_hs   = m_axil_wvalid  & m_axil_wready;
    assign w_b_hs   = m_axil_bvalid  & m_axil_bready;
    assign w_any_hs = w_aw_hs | w_w_hs | w_b_hs;

    // Fires on the TIMEOUT_CYCLES-th consecutive cycle with no handshake.
    assign w_timeout = (TIMEOUT_CYCLES > 0) &&
                       ((r_state == S_XFER) || (r_state == S_RESP)) &&
                       !w_any_hs && (r_timer == TIMER_LAST);

    // State register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (m_axil_awvalid) begin
                    w_next_state = w_grant_onehot ? S_XFER : S_ERR;
                end
            end
            S_XFER: begin
                if (w_timeout) begin
                    w_next_state = S_ERR;
                end else if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) begin
                    w_next_state = S_RESP;
                end
            end
            S_RESP: begin
                if (w_b_hs) begin
                    w_next_state = S_IDLE;
                end else if (w_timeout) begin
                    w_next_state = S_ERR;
                end
            end
            S_ERR: begin
                if (w_b_hs) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        m_axil_awready = 1'b0;
        m_axil_wready  = 1'b0;
        m_axil_bvalid  = 1'b0;
        m_axil_bresp   = 2'b00;
        s_axil_awvalid = '0;
        s_axil_wvalid  = '0;
        s_axil_bready  = '0;
        case (r_state)
            S_XFER: begin
                m_axil_awready = w_sel_awready & ~r_aw_done;
                m_axil_wready  = w_sel_wready  & ~r_w_done;
                s_axil_awvalid = (m_axil_awvalid & ~r_aw_done) ? r_sel : '0;
                s_axil_wvalid  = (m_axil_wvalid  & ~r_w_done)  ? r_sel : '0;
            end
            S_RESP: begin
                m_axil_bvalid = w_sel_bvalid;
                m_axil_bresp  = w_sel_bresp;
                s_axil_bready = m_axil_bready ? r_sel : '0;
            end
            S_ERR: begin
                // Local sink: swallow whatever AW/W is still owed, then answer.
                m_axil_awready = ~r_aw_done;
                m_axil_wready  = ~r_w_done;
                if (r_aw_done & r_w_done) begin
                    m_axil_bvalid = 1'b1;
                    m_axil_bresp  = r_err_code;
                end
            end
            default: ;
        endcase
    end

    // Transaction bookkeeping: route, done flags, error code, stall timer
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_sel      <= '0;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_err_code <= 2'b00;
            r_timer    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_aw_done <= 1'b0;
                    r_w_done  <= 1'b0;
                    r_timer   <= '0;
                    if (m_axil_awvalid) begin
                        if (w_grant_onehot) begin
                            r_sel <= grant_wr_trans;
                        end else begin
                            r_err_code <= 2'b11;
                        end
                    end
                end
                S_XFER, S_RESP: begin
                    if (w_aw_hs) r_aw_done <= 1'b1;
                    if (w_w_hs)  r_w_done  <= 1'b1;
                    if (w_b_hs) begin
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                    end
                    if (w_any_hs || w_timeout) begin
                        r_timer <= '0;
                    end else if (r_timer != '1) begin
                        r_timer <= r_timer + 1'b1;
                    end
                    // Done flags survive the abort so ERR only takes what is still owed.
                    if (w_timeout) r_err_code <= 2'b10;
                end
                S_ERR: begin
                    r_timer <= '0;
                    if (w_aw_hs) r_aw_done <= 1'b1;
                    if (w_w_hs)  r_w_done  <= 1'b1;
                    if (w_b_hs) begin
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axil_crossbar_wr_route.sv
// tb/tb_axil_crossbar_wr_route.sv - bench for axil_crossbar_wr_route

module tb_axil_crossbar_wr_route;

    localparam int NS  = 8;
    localparam int TMO = 16;

    localparam int P_IDLE  = 0;
    localparam int P_DATA  = 1;
    localparam int P_BRESP = 2;
    localparam int P_LOCAL = 3;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic [NS-1:0] grant;
    logic [31:0]   m_axil_awaddr;
    logic          m_axil_awvalid;
    logic          m_axil_awready;
    logic [31:0]   m_axil_wdata;
    logic [3:0]    m_axil_wstrb;
    logic          m_axil_wvalid;
    logic          m_axil_wready;
    logic [1:0]    m_axil_bresp;
    logic          m_axil_bvalid;
    logic          m_axil_bready;
    logic [31:0]   s_axil_awaddr;
    logic [NS-1:0] s_axil_awvalid;
    logic [NS-1:0] s_axil_awready;
    logic [31:0]   s_axil_wdata;
    logic [3:0]    s_axil_wstrb;
    logic [NS-1:0] s_axil_wvalid;
    logic [NS-1:0] s_axil_wready;
    logic [1:0]    s_axil_bresp [NS];
    logic [NS-1:0] s_axil_bvalid;
    logic [NS-1:0] s_axil_bready;
    logic          busy;

    axil_crossbar_wr_route #(
        .NUMBER_SLAVE  (NS),
        .AXI_DATA_WIDTH(32),
        .AXI_ADDR_WIDTH(32),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .grant_wr_trans(grant),
        .m_axil_awaddr (m_axil_awaddr),
        .m_axil_awvalid(m_axil_awvalid),
        .m_axil_awready(m_axil_awready),
        .m_axil_wdata  (m_axil_wdata),
        .m_axil_wstrb  (m_axil_wstrb),
        .m_axil_wvalid (m_axil_wvalid),
        .m_axil_wready (m_axil_wready),
        .m_axil_bresp  (m_axil_bresp),
        .m_axil_bvalid (m_axil_bvalid),
        .m_axil_bready (m_axil_bready),
        .s_axil_awaddr (s_axil_awaddr),
        .s_axil_awvalid(s_axil_awvalid),
        .s_axil_awready(s_axil_awready),
        .s_axil_wdata  (s_axil_wdata),
        .s_axil_wstrb  (s_axil_wstrb),
        .s_axil_wvalid (s_axil_wvalid),
        .s_axil_wready (s_axil_wready),
        .s_axil_bresp  (s_axil_bresp),
        .s_axil_bvalid (s_axil_bvalid),
        .s_axil_bready (s_axil_bready),
        .busy          (busy)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_errs   = 0;

    // Transaction-level model: where the current write is going and what it still owes.
    int         ph;
    int         rt;
    bit         got_aw;
    bit         got_w;
    int         stall;
    logic [1:0] code;
    bit         mdl_aw_hs;
    bit         mdl_w_hs;
    bit         mdl_b_hs;

    typedef struct packed {
        logic          awready;
        logic          wready;
        logic          bvalid;
        logic [1:0]    bresp;
        logic [NS-1:0] s_awvalid;
        logic [NS-1:0] s_wvalid;
        logic [NS-1:0] s_bready;
        logic          busy;
    } exp_t;

    function automatic exp_t predict();
        exp_t e;
        logic [NS-1:0] oh;
        e  = '0;
        oh = 8'b1 << rt;
        case (ph)
            P_DATA: begin
                e.busy    = 1'b1;
                e.awready = s_axil_awready[rt] && !got_aw;
                e.wready  = s_axil_wready[rt] && !got_w;
                if (m_axil_awvalid && !got_aw) e.s_awvalid = oh;
                if (m_axil_wvalid && !got_w)   e.s_wvalid  = oh;
            end
            P_BRESP: begin
                e.busy   = 1'b1;
                e.bvalid = s_axil_bvalid[rt];
                e.bresp  = s_axil_bresp[rt];
                if (m_axil_bready) e.s_bready = oh;
            end
            P_LOCAL: begin
                e.busy    = 1'b1;
                e.awready = !got_aw;
                e.wready  = !got_w;
                if (got_aw && got_w) begin
                    e.bvalid = 1'b1;
                    e.bresp  = code;
                end
            end
            default: ;
        endcase
        return e;
    endfunction

    function automatic int index_of(input logic [NS-1:0] g);
        int idx = 0;
        for (int i = 0; i < NS; i++) if (g[i]) idx = i;
        return idx;
    endfunction

    task automatic reset_model();
        ph = P_IDLE; rt = 0; got_aw = 0; got_w = 0; stall = 0; code = 2'b00;
        mdl_aw_hs = 0; mdl_w_hs = 0; mdl_b_hs = 0;
    endtask

    task automatic model_edge();
        exp_t e;
        bit awh, wh, bh;
        e   = predict();
        awh = m_axil_awvalid && e.awready;
        wh  = m_axil_wvalid && e.wready;
        bh  = e.bvalid && m_axil_bready;
        mdl_aw_hs = awh; mdl_w_hs = wh; mdl_b_hs = bh;
        case (ph)
            P_IDLE: begin
                if (m_axil_awvalid) begin
                    got_aw = 0; got_w = 0; stall = 0;
                    if ($countones(grant) == 1) begin
                        ph = P_DATA;
                        rt = index_of(grant);
                    end else begin
                        ph   = P_LOCAL;
                        code = 2'b11;
                    end
                end
            end
            P_DATA, P_BRESP: begin
                if (awh) got_aw = 1;
                if (wh)  got_w  = 1;
                if (awh || wh || bh) stall = 0;
                else                 stall = stall + 1;
                if (ph == P_BRESP && bh) begin
                    ph = P_IDLE; got_aw = 0; got_w = 0;
                end else if (ph == P_DATA && got_aw && got_w) begin
                    ph = P_BRESP;
                end else if (stall == TMO) begin
                    ph   = P_LOCAL;
                    code = 2'b10;
                end
            end
            default: begin
                if (awh) got_aw = 1;
                if (wh)  got_w  = 1;
                if (bh) begin
                    ph = P_IDLE; got_aw = 0; got_w = 0;
                end
            end
        endcase
    endtask

    task automatic model_loop();
        reset_model();
        forever begin
            @(posedge aclk or negedge aresetn);
            if (!aresetn) reset_model();
            else          model_edge();
        end
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_loop();
        exp_t e;
        forever begin
            @(negedge aclk);
            e = predict();
            cmp("m_awready", 32'(m_axil_awready), 32'(e.awready));
            cmp("m_wready",  32'(m_axil_wready),  32'(e.wready));
            cmp("m_bvalid",  32'(m_axil_bvalid),  32'(e.bvalid));
            cmp("m_bresp",   32'(m_axil_bresp),   32'(e.bresp));
            cmp("s_awvalid", 32'(s_axil_awvalid), 32'(e.s_awvalid));
            cmp("s_wvalid",  32'(s_axil_wvalid),  32'(e.s_wvalid));
            cmp("s_bready",  32'(s_axil_bready),  32'(e.s_bready));
            cmp("busy",      32'(busy),           32'(e.busy));
            cmp("s_awaddr",  s_axil_awaddr,       m_axil_awaddr);
            cmp("s_wdata",   s_axil_wdata,        m_axil_wdata);
            cmp("s_wstrb",   32'(s_axil_wstrb),   32'(m_axil_wstrb));
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic neg();
        @(negedge aclk);
    endtask

    task automatic idle_inputs();
        grant = '0; m_axil_awvalid = 0; m_axil_wvalid = 0; m_axil_bready = 0;
        s_axil_awready = '0; s_axil_wready = '0; s_axil_bvalid = '0;
        for (int i = 0; i < NS; i++) s_axil_bresp[i] = 2'b00;
    endtask

    // Plain routed write: AW+W together to slave idx, slave answers rsp.
    task automatic run_txn(input int idx, input logic [1:0] rsp, input string tag);
        logic [NS-1:0] oh;
        oh = 8'b1 << idx;
        step();
        grant = oh; m_axil_awvalid = 1; m_axil_wvalid = 1;
        m_axil_awaddr = $urandom; m_axil_wdata = $urandom; m_axil_wstrb = 4'hF;
        s_axil_awready = oh; s_axil_wready = oh;
        neg(); cmp({tag, " idle awready"}, 32'(m_axil_awready), 32'd0);
        step();
        neg(); cmp({tag, " s_awvalid"}, 32'(s_axil_awvalid), 32'(oh));
               cmp({tag, " s_wvalid"},  32'(s_axil_wvalid),  32'(oh));
        step();
        m_axil_awvalid = 0; m_axil_wvalid = 0; m_axil_bready = 1;
        s_axil_bvalid = 8'hFF;
        for (int i = 0; i < NS; i++) s_axil_bresp[i] = (i == idx) ? rsp : ~rsp;
        neg(); cmp({tag, " bvalid"},   32'(m_axil_bvalid), 32'd1);
               cmp({tag, " bresp"},    32'(m_axil_bresp),  32'(rsp));
               cmp({tag, " s_bready"}, 32'(s_axil_bready), 32'(oh));
        step(); idle_inputs();
        neg(); cmp({tag, " busy after"}, 32'(busy), 32'd0);
    endtask

    function automatic logic [NS-1:0] rand_grant();
        logic [NS-1:0] g;
        int k;
        k = $urandom_range(0, 7);
        if (k < 5)       g = 8'b1 << $urandom_range(0, NS - 1);
        else if (k == 5) g = '0;
        else begin
            do g = 8'($urandom); while ($countones(g) < 2);
        end
        return g;
    endfunction

    task automatic stimulus();
        logic [NS-1:0] bad_g [2];
        int cnt;
        bit seen;

        // Reset
        repeat (3) step();
        neg();
        cmp("rst busy",     32'(busy),           32'd0);
        cmp("rst bvalid",   32'(m_axil_bvalid),  32'd0);
        cmp("rst bresp",    32'(m_axil_bresp),   32'd0);
        cmp("rst awready",  32'(m_axil_awready), 32'd0);
        cmp("rst s_awvalid",32'(s_axil_awvalid), 32'd0);
        step(); aresetn = 1;

        // T1
        run_txn(2, 2'b00, "T1");
        run_txn(7, 2'b10, "T1b");

        // T2: W leads AW by three cycles; slave0 delays awready
        step(); m_axil_wvalid = 1; m_axil_wdata = 32'hA5A5_0001; s_axil_wready = 8'h01;
        step(); step(); step();
        m_axil_awvalid = 1; grant = 8'h01; m_axil_awaddr = 32'h0000_1000;
        neg(); cmp("T2 idle wready", 32'(m_axil_wready), 32'd0);
        step();
        neg(); cmp("T2 s_wvalid",  32'(s_axil_wvalid),  32'h01);
               cmp("T2 m_awready", 32'(m_axil_awready), 32'd0);
        step(); m_axil_wvalid = 0;
        neg(); cmp("T2 bvalid early", 32'(m_axil_bvalid), 32'd0);
        step(); s_axil_awready = 8'h01;
        neg(); cmp("T2 m_awready", 32'(m_axil_awready), 32'd1);
        step(); m_axil_awvalid = 0; s_axil_bvalid = 8'h01; s_axil_bresp[0] = 2'b01; m_axil_bready = 1;
        neg(); cmp("T2 bvalid", 32'(m_axil_bvalid), 32'd1);
               cmp("T2 bresp",  32'(m_axil_bresp),  32'd1);
        step(); idle_inputs();

        // T3: zero and multi-hot grants answered locally with DECERR
        bad_g[0] = 8'h00; bad_g[1] = 8'h0C;
        foreach (bad_g[j]) begin
            step(); grant = bad_g[j]; m_axil_awvalid = 1; m_axil_wvalid = 1;
            s_axil_awready = 8'hFF; s_axil_wready = 8'hFF;
            step();
            neg(); cmp("T3 s_awvalid", 32'(s_axil_awvalid), 32'd0);
                   cmp("T3 m_awready", 32'(m_axil_awready), 32'd1);
            step(); m_axil_awvalid = 0; m_axil_wvalid = 0;
            neg(); cmp("T3 bvalid", 32'(m_axil_bvalid), 32'd1);
                   cmp("T3 bresp",  32'(m_axil_bresp),  32'd3);
            step(); m_axil_bready = 1;
            step(); idle_inputs();
        end

        // T4: slave5 never ready -> SLVERR after 16 stalled cycles
        step(); grant = 8'h20; m_axil_awvalid = 1; m_axil_wvalid = 1;
        cnt = 0; seen = 0;
        for (int c = 0; c < 40 && !seen; c++) begin
            neg();
            if (s_axil_awvalid != '0) cnt++;
            if (m_axil_bvalid) seen = 1;
            else begin
                step();
                if (mdl_aw_hs) m_axil_awvalid = 0;
                if (mdl_w_hs)  m_axil_wvalid  = 0;
            end
        end
        cmp("T4 stall cycles", 32'(cnt), 32'd16);
        cmp("T4 bvalid seen",  32'(seen), 32'd1);
        cmp("T4 bresp",        32'(m_axil_bresp), 32'd2);
        #1; s_axil_bvalid = 8'h20; m_axil_bready = 1;
        #1; cmp("T4 late s_bready", 32'(s_axil_bready), 32'd0);
        step(); idle_inputs();

        // T5: asynchronous reset while waiting for B
        step(); grant = 8'h02; m_axil_awvalid = 1; m_axil_wvalid = 1;
        s_axil_awready = 8'h02; s_axil_wready = 8'h02;
        step();
        step(); m_axil_awvalid = 0; m_axil_wvalid = 0; s_axil_bvalid = 8'h02;
        neg(); cmp("T5 bvalid pre", 32'(m_axil_bvalid), 32'd1);
        #1; m_axil_bready = 1; aresetn = 0;
        #1; cmp("T5 bvalid rst",   32'(m_axil_bvalid), 32'd0);
            cmp("T5 busy rst",     32'(busy),          32'd0);
            cmp("T5 s_bready rst", 32'(s_axil_bready), 32'd0);
        idle_inputs();
        step(); step(); aresetn = 1;
        run_txn(1, 2'b00, "T5");

        // T6: grant wiggles during XFER, master holds off B for 5 cycles
        step(); grant = 8'h40; m_axil_awvalid = 1; m_axil_wvalid = 1;
        step(); grant = 8'h01;
        neg(); cmp("T6 s_awvalid a", 32'(s_axil_awvalid), 32'h40);
        step(); grant = 8'h81; s_axil_awready = 8'h40; s_axil_wready = 8'h40;
        neg(); cmp("T6 s_awvalid b", 32'(s_axil_awvalid), 32'h40);
        step(); grant = 8'h00; m_axil_awvalid = 0; m_axil_wvalid = 0;
        s_axil_bvalid = 8'h41; s_axil_bresp[6] = 2'b01; s_axil_bresp[0] = 2'b10;
        for (int c = 0; c < 5; c++) begin
            neg(); cmp("T6 bvalid hold", 32'(m_axil_bvalid), 32'd1);
                   cmp("T6 bresp hold",  32'(m_axil_bresp),  32'd1);
            step();
        end
        m_axil_bready = 1;
        neg(); cmp("T6 s_bready", 32'(s_axil_bready), 32'h40);
        step(); idle_inputs();

        // Randomized traffic, with windows where every slave hangs
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step();
            if (mdl_aw_hs) m_axil_awvalid = 0;
            if (mdl_w_hs)  m_axil_wvalid  = 0;
            if (!m_axil_awvalid && $urandom_range(0, 2) == 0) begin
                m_axil_awvalid = 1; m_axil_awaddr = $urandom;
            end
            if (!m_axil_wvalid && $urandom_range(0, 2) == 0) begin
                m_axil_wvalid = 1; m_axil_wdata = $urandom; m_axil_wstrb = 4'($urandom);
            end
            m_axil_bready = ($urandom_range(0, 3) != 0);
            grant = rand_grant();
            if ((cyc % 160) >= 110) begin
                s_axil_awready = '0; s_axil_wready = '0; s_axil_bvalid = '0;
            end else begin
                s_axil_awready = 8'($urandom);
                s_axil_wready  = 8'($urandom);
                s_axil_bvalid  = 8'($urandom);
            end
            for (int i = 0; i < NS; i++) s_axil_bresp[i] = 2'($urandom);
        end
        step(); idle_inputs();
        repeat (40) step();
    endtask

    initial begin
        aresetn = 0;
        m_axil_awaddr = '0; m_axil_wdata = '0; m_axil_wstrb = '0;
        idle_inputs();
        fork
            model_loop();
            check_loop();
            stimulus();
        join_any
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
